// File: rtl/dsp_seq_pkg.sv
// Shared opcodes, DSP48E1 control encodings and default sizing for the op sequencer.
package dsp_seq_pkg;

  localparam int unsigned DSP_LATENCY_DEF = 3;
  localparam int unsigned OP_W            = 2;
  localparam int unsigned A_W             = 25;
  localparam int unsigned B_W             = 18;
  localparam int unsigned BUS_W           = 32;
  localparam int unsigned INMODE_W        = 5;
  localparam int unsigned ALUMODE_W       = 4;
  localparam int unsigned OPMODE_W        = 7;

  typedef enum logic [OP_W-1:0] {
    OP_MUL  = 2'b00,
    OP_MAC  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBC = 2'b11
  } dsp_op_e;

  // Control word presented to the stage alongside the operands.
  typedef struct packed {
    logic [INMODE_W-1:0]  inmode;
    logic [ALUMODE_W-1:0] alumode;
    logic [OPMODE_W-1:0]  opmode;
  } dsp_ctrl_t;

  localparam logic [INMODE_W-1:0]  INMODE_AB    = 5'b00000;
  localparam logic [OPMODE_W-1:0]  OPMODE_MUL   = 7'b000_0101;
  localparam logic [OPMODE_W-1:0]  OPMODE_MAC   = 7'b010_0101;
  localparam logic [OPMODE_W-1:0]  OPMODE_C_AB  = 7'b011_0101;
  localparam logic [OPMODE_W-1:0]  OPMODE_IDLE  = 7'b010_0000;
  localparam logic [ALUMODE_W-1:0] ALUMODE_ADD  = 4'b0000;
  localparam logic [ALUMODE_W-1:0] ALUMODE_ZSUB = 4'b0011;

  // IDLE feeds P back through Z so an accumulator survives issue gaps.
  localparam dsp_ctrl_t CTRL_IDLE = '{inmode: INMODE_AB, alumode: ALUMODE_ADD, opmode: OPMODE_IDLE};

  // Map an opcode to its stage control word.
  function automatic dsp_ctrl_t op_ctrl(input dsp_op_e op);
    dsp_ctrl_t c;
    c = CTRL_IDLE;
    case (op)
      OP_MUL:  c = '{inmode: INMODE_AB, alumode: ALUMODE_ADD,  opmode: OPMODE_MUL};
      OP_MAC:  c = '{inmode: INMODE_AB, alumode: ALUMODE_ADD,  opmode: OPMODE_MAC};
      OP_ADDC: c = '{inmode: INMODE_AB, alumode: ALUMODE_ADD,  opmode: OPMODE_C_AB};
      OP_SUBC: c = '{inmode: INMODE_AB, alumode: ALUMODE_ZSUB, opmode: OPMODE_C_AB};
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dsp_result_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push and pop may coincide even when full.
module dsp_result_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CNT_W-1:0] count_n_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Qualify requests and compute the next occupancy.
  always_comb begin
    do_pop_c  = pop && (count != '0);
    do_push_c = push && ((count != CNT_W'(DEPTH)) || do_pop_c);
    count_n_c = count;
    case ({do_push_c, do_pop_c})
      2'b10:   count_n_c = count + CNT_W'(1);
      2'b01:   count_n_c = count - CNT_W'(1);
      default: count_n_c = count;
    endcase
  end

  // Storage, pointers, occupancy and registered valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count     <= count_n_c;
      out_valid <= (count_n_c != '0);
    end
  end

  assign out_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/dsp_op_sequencer.sv
// Command front-end for a DSP48E1 stage: issues operands/controls, tracks
// the fixed pipeline latency and buffers tagged results under credit control.
module dsp_op_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned DSP_LATENCY = DSP_LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [A_W-1:0]       cmd_a,
  input  logic [B_W-1:0]       cmd_b,
  input  logic [TAG_W-1:0]     cmd_tag,
  output logic [BUS_W-1:0]     a_out,
  output logic [BUS_W-1:0]     b_out,
  output logic [INMODE_W-1:0]  inmode_out,
  output logic [ALUMODE_W-1:0] alumode_out,
  output logic [OPMODE_W-1:0]  opmode_out,
  input  logic [BUS_W-1:0]     p_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BUS_W-1:0]     res_data,
  output logic [TAG_W-1:0]     res_tag
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = TAG_W + BUS_W;

  logic                   accept_c;
  logic                   push_c;
  logic                   pop_c;
  dsp_ctrl_t              ctrl_c;
  logic [SUM_W-1:0]       credit_used_c;
  logic [CNT_W-1:0]       inflight_q;
  logic [CNT_W-1:0]       fifo_count;
  logic                   issue_q;
  logic [TAG_W-1:0]       issue_tag_q;
  logic [DSP_LATENCY-1:0] trk_valid_q;
  logic [TAG_W-1:0]       trk_tag_q [DSP_LATENCY];
  logic [ENTRY_W-1:0]     fifo_out;

  // Credit check: ops in the pipe plus buffered results never exceed FIFO space.
  always_comb begin
    credit_used_c = SUM_W'(inflight_q) + SUM_W'(fifo_count);
    ctrl_c        = op_ctrl(dsp_op_e'(cmd_op));
  end

  assign cmd_ready = !rst && (credit_used_c < SUM_W'(FIFO_DEPTH));
  assign accept_c  = cmd_valid && cmd_ready;
  assign push_c    = trk_valid_q[DSP_LATENCY-1];
  assign pop_c     = res_valid && res_ready;

  // Operand/control issue registers: one-cycle control pulse, operands hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out       <= '0;
      b_out       <= '0;
      inmode_out  <= '0;
      alumode_out <= '0;
      opmode_out  <= OPMODE_IDLE;
      issue_q     <= 1'b0;
      issue_tag_q <= '0;
    end else begin
      issue_q <= accept_c;
      if (accept_c) begin
        a_out       <= {{(BUS_W - A_W){cmd_a[A_W-1]}}, cmd_a};
        b_out       <= {{(BUS_W - B_W){cmd_b[B_W-1]}}, cmd_b};
        inmode_out  <= ctrl_c.inmode;
        alumode_out <= ctrl_c.alumode;
        opmode_out  <= ctrl_c.opmode;
        issue_tag_q <= cmd_tag;
      end else begin
        inmode_out  <= CTRL_IDLE.inmode;
        alumode_out <= CTRL_IDLE.alumode;
        opmode_out  <= CTRL_IDLE.opmode;
      end
    end
  end

  // Latency tracker: tail lines up with the cycle p_in carries the op's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_valid_q <= '0;
      for (int unsigned i = 0; i < DSP_LATENCY; i++) begin
        trk_tag_q[i] <= '0;
      end
    end else begin
      trk_valid_q[0] <= issue_q;
      trk_tag_q[0]   <= issue_tag_q;
      for (int unsigned i = 1; i < DSP_LATENCY; i++) begin
        trk_valid_q[i] <= trk_valid_q[i-1];
        trk_tag_q[i]   <= trk_tag_q[i-1];
      end
    end
  end

  // Outstanding-op counter: up on accept, down on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({accept_c, push_c})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  dsp_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data ({trk_tag_q[DSP_LATENCY-1], p_in}),
    .pop       (pop_c),
    .out_valid (res_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign res_tag  = fifo_out[ENTRY_W-1:BUS_W];
  assign res_data = fifo_out[BUS_W-1:0];

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Bench for dsp_op_sequencer: DSP stage model, command-level result model, directed tests.
module tb_dsp_op_sequencer;

  localparam int unsigned TAG_W   = 4;
  localparam logic [47:0] C_CONST = 48'h95514;
  localparam logic [6:0]  OPM_IDLE = 7'b010_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [24:0]      cmd_a = '0;
  logic [17:0]      cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0]      a_out, b_out, p_in, res_data;
  logic [4:0]       inmode_out;
  logic [3:0]       alumode_out;
  logic [6:0]       opmode_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [TAG_W-1:0] res_tag;

  always #5 clk = ~clk;

  dsp_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .a_out(a_out), .b_out(b_out), .inmode_out(inmode_out),
    .alumode_out(alumode_out), .opmode_out(opmode_out), .p_in(p_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // DSP48E1 stage model: input regs, MREG, PREG; C tied to a constant.
  logic [31:0] s1_a = '0, s1_b = '0;
  logic [6:0]  s1_opm = OPM_IDLE, m_opm = OPM_IDLE;
  logic [3:0]  s1_alu = '0, m_alu = '0;
  logic [47:0] m_reg = '0, p_reg = '0;

  function automatic logic [47:0] stage_p(input logic [6:0] opm, input logic [3:0] alu,
                                          input logic [47:0] m, input logic [47:0] p);
    case (opm)
      7'b000_0101: return m;
      7'b010_0101: return p + m;
      7'b011_0101: return (alu == 4'b0011) ? C_CONST - m : C_CONST + m;
      default:     return p;
    endcase
  endfunction

  always @(posedge clk) begin
    s1_a   <= a_out;
    s1_b   <= b_out;
    s1_opm <= opmode_out;
    s1_alu <= alumode_out;
    m_reg  <= 48'(longint'($signed(s1_a)) * longint'($signed(s1_b)));
    m_opm  <= s1_opm;
    m_alu  <= s1_alu;
    p_reg  <= stage_p(m_opm, m_alu, m_reg, p_reg);
  end
  assign p_in = p_reg[31:0];

  // Command-level model: results computed in issue order, visible 4 edges after accept.
  typedef struct {
    int               due;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } pend_t;

  pend_t       pend_q[$];
  logic [35:0] mfifo_q[$];
  logic [35:0] got_q[$];
  int          got_cyc_q[$];
  logic [47:0] acc = '0;
  int          rise_cyc = -1;
  int          acc_edge = -1;
  logic        res_valid_prev = 1'b0;
  logic        rst_seen = 1'b0;
  logic [6:0]  exp_opm = OPM_IDLE;
  logic [3:0]  exp_alu = '0;
  logic [31:0] exp_a = '0, exp_b = '0;

  function automatic logic [10:0] ctrl_of(input logic [1:0] op);
    case (op)
      2'b00:   return {4'b0000, 7'b000_0101};
      2'b01:   return {4'b0000, 7'b010_0101};
      2'b10:   return {4'b0000, 7'b011_0101};
      default: return {4'b0011, 7'b011_0101};
    endcase
  endfunction

  function automatic logic [47:0] op_result(input logic [1:0] op, input logic [24:0] a,
                                            input logic [17:0] b, input logic [47:0] p);
    logic [47:0] prod;
    prod = 48'(longint'($signed(a)) * longint'($signed(b)));
    case (op)
      2'b00:   return prod;
      2'b01:   return p + prod;
      2'b10:   return C_CONST + prod;
      default: return C_CONST - prod;
    endcase
  endfunction

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    logic        exp_valid, exp_ready;
    logic [10:0] ctl;
    while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mfifo_q.push_back({pend_q[0].tag, pend_q[0].data});
      void'(pend_q.pop_front());
    end
    if (rst_seen) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_opmode", opmode_out, OPM_IDLE);
    end
    exp_valid = (mfifo_q.size() != 0);
    exp_ready = !rst && ((pend_q.size() + mfifo_q.size()) < 4);
    chk("res_valid", res_valid, exp_valid);
    if (exp_valid && res_valid) begin
      chk("res_data", res_data, mfifo_q[0][31:0]);
      chk("res_tag", res_tag, mfifo_q[0][35:32]);
    end
    chk("cmd_ready", cmd_ready, exp_ready);
    chk("opmode", opmode_out, exp_opm);
    chk("alumode", alumode_out, exp_alu);
    chk("inmode", inmode_out, 0);
    chk("a_out", a_out, exp_a);
    chk("b_out", b_out, exp_b);
    if (res_valid && !res_valid_prev) rise_cyc = cyc;
    res_valid_prev = res_valid;

    exp_opm = OPM_IDLE;
    exp_alu = '0;
    if (rst) begin
      exp_a = '0;
      exp_b = '0;
    end else if (cmd_valid && cmd_ready) begin
      acc = op_result(cmd_op, cmd_a, cmd_b, acc);
      pend_q.push_back('{cyc + 5, acc[31:0], cmd_tag});
      acc_edge = cyc + 1;
      ctl = ctrl_of(cmd_op);
      exp_opm = ctl[6:0];
      exp_alu = ctl[10:7];
      exp_a = 32'($signed(cmd_a));
      exp_b = 32'($signed(cmd_b));
    end
    if (!rst && res_ready && mfifo_q.size() > 0) begin
      got_q.push_back(mfifo_q.pop_front());
      got_cyc_q.push_back(cyc);
    end
    if (rst) begin
      pend_q.delete();
      mfifo_q.delete();
    end
    rst_seen = rst;
  end

  task automatic issue(input logic [1:0] op, input logic [24:0] a, input logic [17:0] b,
                       input logic [TAG_W-1:0] tag);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("issue_timeout");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((pend_q.size() != 0 || mfifo_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 200) fail_now(name);
  endtask

  task automatic got_is(input string name, input int idx, input logic [31:0] data,
                        input logic [TAG_W-1:0] tag);
    if (idx >= got_q.size()) begin
      fail_now({name, "_missing"});
    end else begin
      chk({name, "_data"}, got_q[idx][31:0], data);
      chk({name, "_tag"}, got_q[idx][35:32], tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single MUL, latency 4 from accept to res_valid
    res_ready = 1'b1;
    got_q.delete(); got_cyc_q.delete();
    issue(2'b00, 25'd3, 18'd4, 4'd1);
    wait_drain("t1_drain");
    chk("t1_count", 64'(got_q.size()), 1);
    got_is("t1", 0, 32'd12, 4'd1);
    chk("t1_latency", 64'(rise_cyc - acc_edge), 4);

    // 2: back-to-back MUL then MAC
    got_q.delete(); got_cyc_q.delete();
    issue(2'b00, 25'd5, 18'd6, 4'd2);
    issue(2'b01, 25'd2, 18'd3, 4'd3);
    wait_drain("t2_drain");
    got_is("t2_mul", 0, 32'd30, 4'd2);
    got_is("t2_mac", 1, 32'd36, 4'd3);
    if (got_cyc_q.size() >= 2) chk("t2_consecutive", 64'(got_cyc_q[1] - got_cyc_q[0]), 1);
    else fail_now("t2_consecutive");

    // 3: C-path ops and a negative product
    got_q.delete(); got_cyc_q.delete();
    issue(2'b10, 25'd2, 18'd2, 4'd4);
    issue(2'b11, 25'd1, 18'h14, 4'd5);
    issue(2'b00, -25'sd2, 18'd3, 4'd6);
    wait_drain("t3_drain");
    got_is("t3_addc", 0, 32'h0009_5518, 4'd4);
    got_is("t3_subc", 1, 32'h0009_5500, 4'd5);
    got_is("t3_neg", 2, 32'hFFFF_FFFA, 4'd6);

    // 4: back-pressure, credits exhaust after 4 accepts
    res_ready = 1'b0;
    got_q.delete(); got_cyc_q.delete();
    issue(2'b00, 25'd1, 18'd1, 4'd8);
    issue(2'b00, 25'd2, 18'd2, 4'd9);
    issue(2'b00, 25'd3, 18'd3, 4'd10);
    issue(2'b00, 25'd4, 18'd4, 4'd11);
    chk("t4_credit_full", cmd_ready, 0);
    fork
      begin
        issue(2'b00, 25'd5, 18'd5, 4'd12);
        issue(2'b00, 25'd6, 18'd6, 4'd13);
      end
      begin
        repeat (8) @(posedge clk);
        #1 res_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");
    chk("t4_count", 64'(got_q.size()), 6);
    for (int i = 0; i < 6; i++) begin
      got_is("t4", i, 32'((i + 1) * (i + 1)), 4'(8 + i));
    end

    // 5: reset with 2 ops in flight and 1 buffered
    res_ready = 1'b0;
    got_q.delete(); got_cyc_q.delete();
    issue(2'b00, 25'd9, 18'd9, 4'd1);
    repeat (6) @(posedge clk);
    #1;
    issue(2'b00, 25'd2, 18'd5, 4'd2);
    issue(2'b00, 25'd3, 18'd5, 4'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_valid", res_valid, 0);
    chk("t5_rst_opmode", opmode_out, OPM_IDLE);
    chk("t5_rst_alumode", alumode_out, 0);
    chk("t5_rst_ready", cmd_ready, 0);
    chk("t5_rst_a", a_out, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_stale", res_valid, 0);
    res_ready = 1'b1;
    issue(2'b00, 25'd7, 18'd8, 4'd7);
    wait_drain("t5_drain");
    chk("t5_count", 64'(got_q.size()), 1);
    got_is("t5", 0, 32'd56, 4'd7);

    // 6: MAC across idle gap relies on P holding
    got_q.delete(); got_cyc_q.delete();
    issue(2'b00, 25'd7, 18'd7, 4'd3);
    repeat (10) @(posedge clk);
    #1;
    issue(2'b01, 25'd1, 18'd1, 4'd4);
    wait_drain("t6_drain");
    got_is("t6_mul", 0, 32'd49, 4'd3);
    got_is("t6_mac", 1, 32'd50, 4'd4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dsp_op_sequencer.md
Name: dsp_op_sequencer

Overview:
Command front-end that sits directly upstream of the DSP48E1 multiply/ALU stage. It accepts tagged arithmetic commands over a valid/ready handshake and drives the stage's A/B operands and INMODE/ALUMODE/OPMODE control words. It tracks each issued operation through the fixed stage latency and captures the stage's 32-bit P output into a result FIFO, returned in order with the command tag. Credit-based issue guarantees that no result is ever dropped.

Parameters:
DSP_LATENCY, 3, cycles from a_out/b_out/ctrl valid to the matching p_in (input regs + MREG + PREG)
FIFO_DEPTH, 4, result FIFO entries; also the maximum number of outstanding plus buffered ops
TAG_W, 4, command tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 MUL, 01 MAC, 10 ADDC, 11 SUBC
cmd_a  in  25  signed operand A
cmd_b  in  18  signed operand B
cmd_tag  in  TAG_W  opaque tag
a_out  out  32  to stage A; cmd_a sign-extended
b_out  out  32  to stage B; cmd_b sign-extended
inmode_out  out  5  to stage INMODE
alumode_out  out  4  to stage ALUMODE
opmode_out  out  7  to stage OPMODE
p_in  in  32  stage P output
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid && res_ready
res_data  out  32  result value
res_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (rst=1 at a clk edge): a_out=0, b_out=0, inmode_out=0, alumode_out=0, opmode_out=IDLE, res_valid=0, res_data=0, res_tag=0, cmd_ready=0 while rst is asserted. In-flight tracker, FIFO and credit counter are cleared. In-flight results are discarded; p_in is ignored until new issues reach the tracker tail.
- Control encodings (INMODE always 5'b00000):
  - MUL: OPMODE 7'b000_0101, ALUMODE 0000 (P=A*B)
  - MAC: OPMODE 7'b010_0101, ALUMODE 0000 (P=P+A*B)
  - ADDC: OPMODE 7'b011_0101, ALUMODE 0000 (P=C+A*B)
  - SUBC: OPMODE 7'b011_0101, ALUMODE 0011 (P=C-A*B)
  - IDLE: OPMODE 7'b010_0000, ALUMODE 0000 (P holds, so the accumulator survives gaps)
- Issue: on accept, the operand and control registers load at that edge and the outputs are valid the next cycle for exactly one cycle. They return to IDLE control afterwards unless another command is accepted; a_out/b_out hold their last value.
- Tracker: a DSP_LATENCY-deep shift register of {valid, tag} entered at issue. When the tail is valid, p_in is pushed into the FIFO with its tag. Accept-to-push latency is 1+DSP_LATENCY cycles. Throughput is one op per cycle.
- Credits: cmd_ready = !rst && (inflight + fifo_count < FIFO_DEPTH). inflight increments on accept and decrements on push; both in the same cycle leave it unchanged. A push is therefore never blocked by a full FIFO.
- FIFO: show-ahead; res_* reflect the head. Simultaneous push and pop is allowed at any occupancy, including full. Order is strictly FIFO.
- Arithmetic: 48-bit in the stage, truncated to 32 bits at p_in. MAC accumulates in issue order across any number of idle cycles. Overflow wraps silently.

Decomposition:
- Package dsp_seq_pkg: opcode enum; INMODE/OPMODE/ALUMODE constants for MUL/MAC/ADDC/SUBC/IDLE; default DSP_LATENCY.
- One sub-module: dsp_result_fifo (sync FIFO, parameterized width/depth, count output, show-ahead).

Test Plan:
(The bench includes a behavioural stage model with C=48'h95514 and the stated latency.)
1. MUL a=3, b=4, tag=1 -> res_data=12, res_tag=1, res_valid rises exactly 4 cycles after accept.
2. Back-to-back MUL 5*6 (tag 2), then MAC 2*3 (tag 3) -> results 30 then 36, in order, on consecutive cycles.
3. ADDC 2*2 -> 0x95518; SUBC 1*0x14 -> 0x95500; MUL -2*3 -> 0xFFFFFFFA.
4. res_ready=0, drive 6 commands -> cmd_ready low after the 4th accept; raise res_ready -> 4 results in order, then the remaining 2 are accepted and returned; none lost or duplicated.
5. Assert rst with 2 ops in flight and 1 buffered -> res_valid=0 and controls IDLE after the edge, no stale results later; then MUL 7*8 -> 56.
6. MUL 7*7, then 10 idle cycles, then MAC 1*1 -> 49 then 50, confirming IDLE holds P.
